// File: rtl/rbb_pkg.sv
// Shared definitions for the result-batch-buffer write arbiter: FSM states,
// batch counter width and the batch line-count helper.
package rbb_pkg;

  localparam int unsigned BATCH_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ARB,
    SEND,
    GAP
  } arb_state_t;

  // Lines per batch for a given line index width.
  function automatic int unsigned line_count(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/rbb_wr_arbiter_if.sv
// Host write channel of the result batch arbiter: request strobe/address/data
// out, back-pressure and completion strobe in.
interface rbb_wr_arbiter_if #(
  parameter int unsigned MEM_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = 512
) ();

  logic                      wr_almost_full;
  logic                      wr_req_valid;
  logic [MEM_ADDR_WIDTH-1:0] wr_req_addr;
  logic [DATA_WIDTH-1:0]     wr_req_data;
  logic                      wr_rsp_valid;

  modport master (
    output wr_req_valid,
    output wr_req_addr,
    output wr_req_data,
    input  wr_almost_full,
    input  wr_rsp_valid
  );

  modport slave (
    input  wr_req_valid,
    input  wr_req_addr,
    input  wr_req_data,
    output wr_almost_full,
    output wr_rsp_valid
  );

endinterface

// File: rtl/rbb_rr_pick.sv
// Rotating priority encoder: first asserted request at or after ptr, wrapping.
module rbb_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned p, input int unsigned k);
    return IDX_W'((p + k) % N);
  endfunction

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!hit && req[wrap_idx(32'(ptr), k)]) begin
        hit = 1'b1;
        idx = wrap_idx(32'(ptr), k);
      end
    end
  end

endmodule

// File: rtl/rbb_wr_arbiter.sv
// Round-robin arbiter turning result batch buffer lines into host write requests.
// Optional line-order checking is built when RBB_WR_ARB_CHECK_EN is defined.
module rbb_wr_arbiter
  import rbb_pkg::*;
#(
  parameter int unsigned NUM_RBB         = 4,
  parameter int unsigned LINE_ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned MEM_ADDR_WIDTH  = 32,
  parameter int unsigned MAX_OUTSTANDING = 64
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_RBB-1:0]                 rbb_req_valid,
  input  logic [NUM_RBB*LINE_ADDR_WIDTH-1:0] rbb_line_idx,
  input  logic [NUM_RBB*DATA_WIDTH-1:0]      rbb_rd_dout,
  output logic [NUM_RBB-1:0]                 rbb_req_ack,
  input  logic [MEM_ADDR_WIDTH-1:0]          result_base_addr,
  rbb_wr_arbiter_if.master                   wr,
  output logic                               batch_done,
  output logic [BATCH_CNT_WIDTH-1:0]         batch_count,
  output logic                               idle,
  output logic                               seq_err
);

  localparam int unsigned SEL_W = (NUM_RBB > 1) ? $clog2(NUM_RBB) : 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [LINE_ADDR_WIDTH-1:0] LAST_LINE =
    LINE_ADDR_WIDTH'(line_count(LINE_ADDR_WIDTH) - 1);

  arb_state_t                 state, state_nxt;
  logic [SEL_W-1:0]           sel, rr_ptr, pick_idx;
  logic                       pick_hit;
  logic [LINE_ADDR_WIDTH-1:0] line_cnt;
  logic [OUT_W-1:0]           outstanding;
  logic                       stall, issue, rsp_take;
  logic [LINE_ADDR_WIDTH-1:0] cur_idx;
  logic [DATA_WIDTH-1:0]      cur_data;

  rbb_rr_pick #(
    .N     (NUM_RBB),
    .IDX_W (SEL_W)
  ) u_pick (
    .req (rbb_req_valid),
    .ptr (rr_ptr),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  assign cur_idx  = rbb_line_idx[sel*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH];
  assign cur_data = rbb_rd_dout[sel*DATA_WIDTH +: DATA_WIDTH];
  assign stall    = wr.wr_almost_full | (outstanding == OUT_W'(MAX_OUTSTANDING));
  assign rsp_take = wr.wr_rsp_valid & (outstanding != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ARB;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    rbb_req_ack = '0;
    issue       = 1'b0;
    unique case (state)
      ARB:  if (pick_hit) state_nxt = SEND;
      SEND: begin
        if (!stall) begin
          issue            = 1'b1;
          rbb_req_ack[sel] = 1'b1;
          state_nxt        = GAP;
        end
      end
      GAP:     state_nxt = (line_cnt == LAST_LINE) ? ARB : SEND;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel             <= '0;
      rr_ptr          <= '0;
      line_cnt        <= '0;
      wr.wr_req_valid <= 1'b0;
      wr.wr_req_addr  <= '0;
      wr.wr_req_data  <= '0;
      batch_done      <= 1'b0;
      batch_count     <= '0;
      outstanding     <= '0;
      idle            <= 1'b1;
    end else begin
      wr.wr_req_valid <= issue;
      // Registered on the issuing edge so the pulse lands in the GAP cycle.
      batch_done      <= issue && (line_cnt == LAST_LINE);

      if (state == ARB && pick_hit) begin
        sel      <= pick_idx;
        line_cnt <= '0;
      end

      if (issue) begin
        wr.wr_req_addr <= result_base_addr + MEM_ADDR_WIDTH'({batch_count, cur_idx});
        wr.wr_req_data <= cur_data;
      end

      if (state == GAP) begin
        if (line_cnt == LAST_LINE) begin
          batch_count <= batch_count + 1'b1;
          rr_ptr      <= (sel == SEL_W'(NUM_RBB - 1)) ? '0 : sel + 1'b1;
        end else begin
          line_cnt <= line_cnt + 1'b1;
        end
      end

      if (issue && !rsp_take)      outstanding <= outstanding + 1'b1;
      else if (!issue && rsp_take) outstanding <= outstanding - 1'b1;

      idle <= (state == ARB) && !(|rbb_req_valid) && (outstanding == '0);
    end
  end

`ifdef RBB_WR_ARB_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset_n)                        seq_err <= 1'b0;
    else if (issue && cur_idx != line_cnt) seq_err <= 1'b1;
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_rbb_wr_arbiter.sv
// Bench for rbb_wr_arbiter: buffer and write-channel models with a queue-based
// expected write stream derived from batch/round-robin rules.
`timescale 1ns/1ps
module tb_rbb_wr_arbiter;

  localparam int unsigned NB = 4, LW = 8, DW = 512, AW = 32, MO = 4;
  localparam int LINES = 256;
`ifdef RBB_WR_ARB_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NB-1:0]    rbb_req_valid, rbb_req_ack, ack_s;
  logic [NB*LW-1:0] rbb_line_idx;
  logic [NB*DW-1:0] rbb_rd_dout;
  logic [AW-1:0]    result_base_addr;
  logic             batch_done, idle, seq_err;
  logic [15:0]      batch_count;

  rbb_wr_arbiter_if #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wr_bus ();

  rbb_wr_arbiter #(
    .NUM_RBB(NB), .LINE_ADDR_WIDTH(LW), .DATA_WIDTH(DW),
    .MEM_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rbb_req_valid(rbb_req_valid), .rbb_line_idx(rbb_line_idx),
    .rbb_rd_dout(rbb_rd_dout), .rbb_req_ack(rbb_req_ack),
    .result_base_addr(result_base_addr), .wr(wr_bus.master),
    .batch_done(batch_done), .batch_count(batch_count),
    .idle(idle), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] cap_addr[$], exp_addr[$];
  logic [DW-1:0] cap_data[$], exp_data[$];
  int            cap_cyc[$];
  int            done_cnt, done_cyc, pend, rsp_pct, manual_rsp;
  bit            rsp_hold, stray_rsp, af_rand;
  bit            bvalid[NB];
  int            bidx[NB], bskip[NB];
  logic [31:0]   btag[NB];

  function automatic logic [DW-1:0] data_of(input logic [31:0] tag, input int idx);
    return {16{tag ^ 32'(idx)}};
  endfunction

  // Channel monitor/responder plus buffer models (advance a line the cycle after an ack).
  initial begin
    forever begin
      @(negedge clk);
      if (wr_bus.wr_req_valid === 1'b1) begin
        cap_addr.push_back(wr_bus.wr_req_addr);
        cap_data.push_back(wr_bus.wr_req_data);
        cap_cyc.push_back(cyc);
        pend++;
      end
      if (batch_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      ack_s = rbb_req_ack;
      @(posedge clk);
      #1;
      if (stray_rsp) begin
        wr_bus.wr_rsp_valid = 1'b1;
        stray_rsp = 1'b0;
      end else if (pend > 0 && manual_rsp > 0) begin
        wr_bus.wr_rsp_valid = 1'b1;
        manual_rsp--;
        pend--;
      end else if (pend > 0 && !rsp_hold && $urandom_range(99) < rsp_pct) begin
        wr_bus.wr_rsp_valid = 1'b1;
        pend--;
      end else begin
        wr_bus.wr_rsp_valid = 1'b0;
      end
      if (af_rand) wr_bus.wr_almost_full = ($urandom_range(99) < 20);
      for (int b = 0; b < NB; b++) begin
        if (ack_s[b] === 1'b1 && bvalid[b]) begin
          if (bidx[b] == LINES - 1)  bvalid[b] = 1'b0;
          else if (bidx[b] == bskip[b]) bidx[b] += 2;
          else                       bidx[b]++;
        end
        rbb_req_valid[b]             = bvalid[b];
        rbb_line_idx[b*LW +: LW]     = LW'(bidx[b]);
        rbb_rd_dout[b*DW +: DW]      = data_of(btag[b], bidx[b]);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_buf(input int b, input logic [31:0] tag);
    btag[b] = tag;
    bidx[b] = 0;
    bvalid[b] = 1'b1;
  endtask

  task automatic push_batch(input logic [31:0] tag, input logic [AW-1:0] base, input int bnum);
    for (int i = 0; i < LINES; i++) begin
      exp_addr.push_back(base + AW'(bnum * LINES + i));
      exp_data.push_back(data_of(tag, i));
    end
  endtask

  task automatic clear_caps();
    cap_addr.delete(); cap_data.delete(); cap_cyc.delete();
    exp_addr.delete(); exp_data.delete();
    done_cnt = 0;
  endtask

  function automatic int first_mismatch();
    if (cap_addr.size() != exp_addr.size()) return -2;
    for (int i = 0; i < cap_addr.size(); i++)
      if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) return i;
    return -1;
  endfunction

  task automatic wait_caps(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (cap_addr.size() >= n) ok = 1'b1;
      else step(1);
    end
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (done_cnt >= n) ok = 1'b1;
      else step(1);
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (idle === 1'b1 && pend == 0) ok = 1'b1;
      else step(1);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int b = 0; b < NB; b++) begin
      bvalid[b] = 1'b0; bidx[b] = 0; bskip[b] = -1;
    end
    pend = 0; manual_rsp = 0; rsp_hold = 1'b0; af_rand = 1'b0; rsp_pct = 100;
    wr_bus.wr_almost_full = 1'b0;
    step(2);
    clear_caps();
    pend = 0;
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(2);
    checks++; if (rbb_req_ack !== '0) begin errors++; $display("FAIL rst_ack: got %h want 0", rbb_req_ack); end
    checks++; if (wr_bus.wr_req_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", wr_bus.wr_req_valid); end
    checks++; if (wr_bus.wr_req_addr !== '0) begin errors++; $display("FAIL rst_addr: got %h want 0", wr_bus.wr_req_addr); end
    checks++; if (wr_bus.wr_req_data !== '0) begin errors++; $display("FAIL rst_data: got nonzero want 0"); end
    checks++; if (batch_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", batch_done); end
    checks++; if (batch_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", batch_count); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b want 1", idle); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL rst_seq_err: got %b want 0", seq_err); end
    do_reset();
    step(2);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL idle_after_rst: got %b want 1", idle); end
  endtask

  task automatic test_single();
    bit ok; int fm, bad_gap, t0;
    logic [31:0] tag;
    do_reset();
    result_base_addr = 32'h1000;
    tag = $urandom;
    t0 = cyc;
    start_buf(0, tag);
    push_batch(tag, 32'h1000, 0);
    wait_done(1, 1500, ok);
    step(4);
    checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout: batch_done count %0d want 1", done_cnt); end
    fm = first_mismatch();
    checks++; if (fm != -1) begin errors++; $display("FAIL single_seq: bad entry %0d (want -1), writes %0d want %0d", fm, cap_addr.size(), exp_addr.size()); end
    if (cap_cyc.size() == LINES) begin
      bad_gap = 0;
      for (int i = 1; i < LINES; i++) if (cap_cyc[i] - cap_cyc[i-1] != 2) bad_gap++;
      checks++; if (bad_gap != 0) begin errors++; $display("FAIL single_spacing: %0d gaps not 2 cycles, want 0", bad_gap); end
      checks++; if (cap_cyc[0] - t0 != 3) begin errors++; $display("FAIL single_latency: first write %0d cycles after valid set, want 3", cap_cyc[0] - t0); end
      checks++; if (done_cyc != cap_cyc[LINES-1]) begin errors++; $display("FAIL single_done_cycle: got %0d want %0d", done_cyc, cap_cyc[LINES-1]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (batch_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", batch_count); end
    wait_idle(100, ok);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b want 1 (pending %0d)", idle, pend); end
  endtask

  task automatic test_round_robin();
    bit ok; int fm;
    logic [31:0] t1, t2;
    do_reset();
    result_base_addr = 32'h1000;
    t1 = $urandom; t2 = $urandom;
    start_buf(1, t1); start_buf(2, t2);
    push_batch(t1, 32'h1000, 0);
    push_batch(t2, 32'h1000, 1);
    wait_done(2, 3000, ok);
    step(4);
    fm = first_mismatch();
    checks++; if (fm != -1) begin errors++; $display("FAIL rr_seq: bad entry %0d (want -1), writes %0d want %0d", fm, cap_addr.size(), exp_addr.size()); end
    checks++; if (batch_count !== 16'd2) begin errors++; $display("FAIL rr_count: got %0d want 2", batch_count); end
    checks++; if (done_cnt != 2) begin errors++; $display("FAIL rr_done_cnt: got %0d want 2", done_cnt); end
    wait_idle(100, ok);
  endtask

  task automatic test_backpressure();
    bit ok; int fm, bad_ack, bad_valid;
    logic [31:0] tag, base;
    do_reset();
    base = $urandom;
    result_base_addr = base;
    tag = $urandom;
    start_buf(3, tag);
    push_batch(tag, base, 0);
    wait_caps(50, 400, ok);
    wr_bus.wr_almost_full = 1'b1;
    bad_ack = 0; bad_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rbb_req_ack !== '0) bad_ack++;
      if (i > 0 && wr_bus.wr_req_valid !== 1'b0) bad_valid++;
      @(posedge clk);
      #2;
    end
    wr_bus.wr_almost_full = 1'b0;
    checks++; if (bad_ack != 0) begin errors++; $display("FAIL bp_ack: %0d acks during hold, want 0", bad_ack); end
    checks++; if (bad_valid != 0) begin errors++; $display("FAIL bp_valid: %0d requests during hold, want 0", bad_valid); end
    wait_done(1, 1500, ok);
    step(4);
    fm = first_mismatch();
    checks++; if (fm != -1) begin errors++; $display("FAIL bp_seq: bad entry %0d (want -1), writes %0d want %0d", fm, cap_addr.size(), exp_addr.size()); end
    wait_idle(100, ok);
  endtask

  task automatic test_credit();
    do_reset();
    result_base_addr = 32'h2000;
    stray_rsp = 1'b1;
    step(3);
    rsp_hold = 1'b1;
    btag[1] = $urandom;
    start_buf(1, btag[1]);
    push_batch(btag[1], 32'h2000, 0);
    step(60);
    checks++; if (cap_addr.size() != MO) begin errors++; $display("FAIL credit_limit: got %0d writes want %0d", cap_addr.size(), MO); end
    checks++; if (rbb_req_ack !== '0) begin errors++; $display("FAIL credit_ack: got %h want 0 while stalled", rbb_req_ack); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL credit_idle: got %b want 0", idle); end
    manual_rsp = 1;
    step(20);
    checks++; if (cap_addr.size() != MO + 1) begin errors++; $display("FAIL credit_release: got %0d writes want %0d", cap_addr.size(), MO + 1); end
  endtask

  task automatic test_simultaneous();
    bit ok; int fm;
    // Second response lands on the same edge as the released issue.
    manual_rsp = 2;
    step(20);
    checks++; if (cap_addr.size() != MO + 3) begin errors++; $display("FAIL simul_release: got %0d writes want %0d", cap_addr.size(), MO + 3); end
    rsp_hold = 1'b0;
    rsp_pct = 100;
    wait_done(1, 1500, ok);
    step(4);
    fm = first_mismatch();
    checks++; if (fm != -1) begin errors++; $display("FAIL credit_seq: bad entry %0d (want -1), writes %0d want %0d", fm, cap_addr.size(), exp_addr.size()); end
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL credit_idle_end: idle %b pending %0d, want 1 and 0", idle, pend); end
  endtask

  task automatic test_random();
    bit ok; int fm, rr_model, batch_model, nb, last;
    logic [3:0]  subset;
    logic [31:0] base;
    int          order[$];
    do_reset();
    rr_model = 0; batch_model = 0;
    for (int r = 0; r < 3; r++) begin
      clear_caps();
      order.delete();
      subset = 4'($urandom_range(15, 1));
      base = $urandom;
      result_base_addr = base;
      for (int k = 0; k < NB; k++) begin
        int b;
        b = (rr_model + k) % NB;
        if (subset[b]) order.push_back(b);
      end
      nb = order.size();
      foreach (order[i]) begin
        btag[order[i]] = $urandom;
        push_batch(btag[order[i]], base, batch_model);
        batch_model++;
        start_buf(order[i], btag[order[i]]);
      end
      last = order[nb-1];
      rr_model = (last + 1) % NB;
      af_rand = 1'b1;
      rsp_pct = 50;
      wait_done(nb, 4000 * nb, ok);
      af_rand = 1'b0;
      wr_bus.wr_almost_full = 1'b0;
      rsp_pct = 100;
      wait_idle(200, ok);
      fm = first_mismatch();
      checks++; if (fm != -1) begin errors++; $display("FAIL rand_seq round %0d: bad entry %0d (want -1), writes %0d want %0d", r, fm, cap_addr.size(), exp_addr.size()); end
      checks++; if (batch_count !== 16'(batch_model)) begin errors++; $display("FAIL rand_count round %0d: got %0d want %0d", r, batch_count, batch_model); end
    end
  endtask

  task automatic test_seq_err();
    bit ok; int fm, idx;
    logic [31:0] tag;
    do_reset();
    result_base_addr = 32'h3000;
    tag = $urandom;
    bskip[0] = 5;
    idx = 0;
    for (int i = 0; i < LINES; i++) begin
      exp_addr.push_back(32'h3000 + 32'(idx));
      exp_data.push_back(data_of(tag, idx));
      if (idx == 5) idx = 7;
      else if (idx < LINES - 1) idx++;
    end
    start_buf(0, tag);
    wait_done(1, 1500, ok);
    step(4);
    fm = first_mismatch();
    checks++; if (fm != -1) begin errors++; $display("FAIL seq_skip_stream: bad entry %0d (want -1), writes %0d want %0d", fm, cap_addr.size(), exp_addr.size()); end
    checks++; if (seq_err !== CHECK_EN) begin errors++; $display("FAIL seq_err_set: got %b want %b", seq_err, CHECK_EN); end
    step(10);
    checks++; if (seq_err !== CHECK_EN) begin errors++; $display("FAIL seq_err_sticky: got %b want %b", seq_err, CHECK_EN); end
    bskip[0] = -1;
    wait_idle(100, ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_caps();
    btag[2] = $urandom;
    start_buf(2, btag[2]);
    wait_caps(100, 600, ok);
    reset_n = 1'b0;
    for (int b = 0; b < NB; b++) bvalid[b] = 1'b0;
    step(1);
    checks++; if (!ok) begin errors++; $display("FAIL mid_reach: got %0d writes want 100", cap_addr.size()); end
    checks++; if (rbb_req_ack !== '0) begin errors++; $display("FAIL mid_ack: got %h want 0", rbb_req_ack); end
    checks++; if (wr_bus.wr_req_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", wr_bus.wr_req_valid); end
    checks++; if (wr_bus.wr_req_addr !== '0) begin errors++; $display("FAIL mid_addr: got %h want 0", wr_bus.wr_req_addr); end
    checks++; if (wr_bus.wr_req_data !== '0) begin errors++; $display("FAIL mid_data: got nonzero want 0"); end
    checks++; if (batch_done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b want 0", batch_done); end
    checks++; if (batch_count !== 16'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", batch_count); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle: got %b want 1", idle); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL mid_seq_err: got %b want 0", seq_err); end
    do_reset();
    step(4);
    checks++; if (cap_addr.size() != 0) begin errors++; $display("FAIL mid_abandon: got %0d writes after reset want 0", cap_addr.size()); end
  endtask

  initial begin
    reset_n = 1'b0;
    rbb_req_valid = '0;
    rbb_line_idx = '0;
    rbb_rd_dout = '0;
    result_base_addr = '0;
    wr_bus.wr_almost_full = 1'b0;
    wr_bus.wr_rsp_valid = 1'b0;
    pend = 0; manual_rsp = 0; rsp_pct = 100;
    rsp_hold = 1'b0; stray_rsp = 1'b0; af_rand = 1'b0;
    done_cnt = 0; done_cyc = 0;
    for (int b = 0; b < NB; b++) begin
      bvalid[b] = 1'b0; bidx[b] = 0; bskip[b] = -1; btag[b] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_credit();
    test_simultaneous();
    test_random();
    test_seq_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
